// File: rtl/rx_tx_pkg.sv
// ---------------------------------------------------------------------------
// rx_tx_pkg
// Shared definitions for the serial Tx/Rx data units on the board link.
//   state_t      : frame-engine state encoding used by both directions
//   FRAME_BITS   : line bits per frame (start + 9 data + parity + stop)
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (and of the idle line)
//   EVEN_PARITY  : Parity select value for even parity
//   ODD_PARITY   : Parity select value for odd parity
// ---------------------------------------------------------------------------
package rx_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   FRAME_BITS  = 12;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic EVEN_PARITY = 1'b0;
    localparam logic ODD_PARITY  = 1'b1;

endpackage

// File: rtl/rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// rx_sync_2ff
// Two-stage synchroniser for an asynchronous pin input. Both stages reset to
// 1 so an idle-high serial line never shows a false low after reset.
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output (2 Clock latency)
// ---------------------------------------------------------------------------
module rx_sync_2ff (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_data_unit_summer2021hust.sv
// ---------------------------------------------------------------------------
// rx_data_unit_summer2021hust
// Serial receive data unit: detects the start bit, samples each bit at its
// mid-point using the shared oversample tick, deserialises DataLength bits
// LSB first, checks parity and stop bit, and publishes word plus flags.
//   Clock       : system clock, rising edge
//   Reset       : synchronous, active-high
//   Rx          : serial line, idle high, asynchronous
//   SampleTick  : one-Clock pulse, Oversample per bit period
//   Parity      : 0 even / 1 odd, latched when the start bit is confirmed
//   Data        : last received word, held until the next frame completes
//   DataReady   : one-Clock pulse when Data and flags update
//   ParityError : parity mismatch on the last frame
//   FrameError  : stop bit sampled low on the last frame
//   Busy        : high whenever a frame is in progress
// ---------------------------------------------------------------------------
module rx_data_unit_summer2021hust
    import rx_tx_pkg::*;
#(
    parameter int DataLength = 9,
    parameter int Oversample = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Rx,
    input  logic                  SampleTick,
    input  logic                  Parity,
    output logic [DataLength-1:0] Data,
    output logic                  DataReady,
    output logic                  ParityError,
    output logic                  FrameError,
    output logic                  Busy
);

    localparam int TW = $clog2(Oversample);
    localparam int BW = $clog2(DataLength + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(Oversample / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(Oversample - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DataLength - 1);

    logic                  rx_sync;
    state_t                state;
    state_t                state_next;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DataLength-1:0] shift;
    logic                  par_sel;
    logic                  par_bit;
    logic                  stop_bit;
    logic                  stop_seen;
    logic                  tick_mid;
    logic                  tick_end;

    rx_sync_2ff u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (Rx),
        .q     (rx_sync)
    );

    assign tick_mid = SampleTick && (tick_cnt == TICK_HALF);
    assign tick_end = SampleTick && (tick_cnt == TICK_LAST);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (SampleTick && rx_sync == START_BIT) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick_mid) begin
                    state_next = (rx_sync == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (tick_end && bit_cnt == BIT_LAST) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Stop bit is sampled first; publish and leave one Clock later.
                if (stop_seen) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state != IDLE);
    end

    // Counters, shift register and published outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_sel     <= EVEN_PARITY;
            par_bit     <= 1'b0;
            stop_bit    <= 1'b0;
            stop_seen   <= 1'b0;
            Data        <= '0;
            DataReady   <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
        end else begin
            DataReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (SampleTick && rx_sync == START_BIT) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (SampleTick) begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            if (rx_sync == START_BIT) begin
                                par_sel <= Parity;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (SampleTick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            // Right shift from the MSB leaves D[0] in bit 0.
                            shift    <= {rx_sync, shift[DataLength-1:1]};
                            bit_cnt  <= bit_cnt + BW'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (SampleTick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            par_bit  <= rx_sync;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (stop_seen) begin
                        stop_seen   <= 1'b0;
                        Data        <= shift;
                        ParityError <= par_bit ^ par_sel ^ (^shift);
                        FrameError  <= (stop_bit != STOP_BIT);
                        DataReady   <= 1'b1;
                    end else if (SampleTick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            stop_bit  <= rx_sync;
                            stop_seen <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_data_unit_summer2021hust.sv
// ---------------------------------------------------------------------------
// tb_rx_data_unit_summer2021hust
// Drives serial frames onto Rx, collects every DataReady publication and
// compares it with the word/flags predicted from the frame contents.
// ---------------------------------------------------------------------------
module tb_rx_data_unit_summer2021hust;
    import rx_tx_pkg::*;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       Clock;
    logic       Reset;
    logic       Rx;
    logic       SampleTick;
    logic       Parity;
    logic [8:0] Data;
    logic       DataReady;
    logic       ParityError;
    logic       FrameError;
    logic       Busy;

    int   checks = 0;
    int   errors = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t last_pub;

    rx_data_unit_summer2021hust #(
        .DataLength (9),
        .Oversample (16)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Rx          (Rx),
        .SampleTick  (SampleTick),
        .Parity      (Parity),
        .Data        (Data),
        .DataReady   (DataReady),
        .ParityError (ParityError),
        .FrameError  (FrameError),
        .Busy        (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One tick every fourth Clock
    initial begin
        int div;
        div = 0;
        SampleTick = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            div = (div + 1) % 4;
            SampleTick = (div == 0);
        end
    end

    // Record every publication
    always @(negedge Clock) begin
        if (DataReady === 1'b1) begin
            got_q.push_back('{d: Data, pe: ParityError, fe: FrameError});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge Clock iff SampleTick === 1'b1);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        wait_ticks(16);
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        wait_ticks(n);
    endtask

    // Sends start/data/parity/stop; expectation derived from frame content
    task automatic send_frame(input logic [8:0] d, input logic p, input logic stop,
                              input logic par, input bit scramble);
        rec_t e;
        Parity = par;
        send_bit(START_BIT);
        if (scramble) Parity = 1'($urandom_range(0, 1));
        for (int i = 0; i < FRAME_BITS - 3; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        e.d  = d;
        e.pe = (p != (par ^ (^d)));
        e.fe = (stop != STOP_BIT);
        exp_q.push_back(e);
        last_pub = e;
    endtask

    function automatic logic good_p(input logic [8:0] d, input logic par);
        return par ^ (^d);
    endfunction

    task automatic check_queue(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_data"}, got_q[i].d,  exp_q[i].d);
            chk({tag, "_pe"},   got_q[i].pe, exp_q[i].pe);
            chk({tag, "_fe"},   got_q[i].fe, exp_q[i].fe);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_busy"}, Busy, 1'b0);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_data"}, Data,        last_pub.d);
        chk({tag, "_pe"},   ParityError, last_pub.pe);
        chk({tag, "_fe"},   FrameError,  last_pub.fe);
        chk({tag, "_dr"},   DataReady,   1'b0);
    endtask

    initial begin
        logic [8:0] d;
        logic       par;
        logic       p;
        logic       stop;
        Reset  = 1'b1;
        Rx     = 1'b1;
        Parity = EVEN_PARITY;
        last_pub = '{d: '0, pe: 1'b0, fe: 1'b0};
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_held("reset");
        chk("reset_busy", Busy, 1'b0);
        Reset = 1'b0;
        idle(4);

        // 1: even parity, clean frame
        send_frame(9'h1A5, 1'b1, 1'b1, EVEN_PARITY, 1'b0);
        idle(8);
        check_queue("t1");

        // 2: odd parity, correct then wrong parity bit
        send_frame(9'h0FF, 1'b1, 1'b1, ODD_PARITY, 1'b0);
        idle(8);
        send_frame(9'h0FF, 1'b0, 1'b1, ODD_PARITY, 1'b0);
        idle(8);
        check_queue("t2");

        // 3: break frame, line then held low for two more frames
        send_frame(9'h1A5, 1'b1, 1'b0, EVEN_PARITY, 1'b0);
        exp_q.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b1});
        exp_q.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b1});
        last_pub = '{d: 9'h000, pe: 1'b0, fe: 1'b1};
        Rx = 1'b0;
        wait_ticks(368);
        idle(40);
        check_queue("t3");

        // 4: false start
        Rx = 1'b0;
        wait_ticks(5);
        idle(30);
        check_queue("t4");
        check_held("t4_hold");

        // 5: reset during data bit 4
        Parity = EVEN_PARITY;
        d = 9'h1F0;
        send_bit(START_BIT);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Rx = d[4];
        wait_ticks(8);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        last_pub = '{d: '0, pe: 1'b0, fe: 1'b0};
        check_held("t5_reset");
        chk("t5_busy", Busy, 1'b0);
        idle(40);
        check_queue("t5_nopub");
        send_frame(9'h055, 1'b0, 1'b1, EVEN_PARITY, 1'b0);
        idle(8);
        check_queue("t5");

        // 6: back-to-back frames
        send_frame(9'h001, good_p(9'h001, ODD_PARITY), 1'b1, ODD_PARITY, 1'b0);
        send_frame(9'h100, good_p(9'h100, ODD_PARITY), 1'b1, ODD_PARITY, 1'b0);
        send_frame(9'h1FF, good_p(9'h1FF, ODD_PARITY), 1'b1, ODD_PARITY, 1'b0);
        idle(8);
        check_queue("t6");
        check_held("t6_hold");

        // Random frames; Parity scrambled after the start bit
        for (int n = 0; n < 15; n++) begin
            d    = 9'($urandom);
            par  = 1'($urandom_range(0, 1));
            p    = good_p(d, par) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, p, stop, par, 1'b1);
            idle(stop ? int'($urandom_range(0, 3)) : 20);
        end
        idle(8);
        check_queue("rand");
        check_held("rand_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_data_unit_summer2021hust.md
Name: rx_data_unit_summer2021hust

Overview:
Serial receive data unit; the far end of the existing Tx data unit on the same serial link. It detects the start bit, oversamples each bit at mid-point and deserialises 9 data bits, LSB first. It checks parity (even/odd selectable) and the stop bit, then presents the word with status flags. It sits between the board Rx pin and the receive control/FIFO logic, and is driven by a shared baud-rate oversample tick.

Parameters:
DataLength, 9, number of data bits per frame.
Oversample, 16, SampleTick pulses per bit period; even, at least 4.

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
Rx  input  1  serial line, idle high; asynchronous to Clock.
SampleTick  input  1  one-Clock-wide pulse, Oversample per bit period.
Parity  input  1  0 = even parity, 1 = odd parity; sampled at start-bit confirmation.
Data  output  DataLength  last received word; holds until the next frame completes.
DataReady  output  1  one-Clock pulse when Data and the flags update.
ParityError  output  1  received parity bit mismatched, for the last frame.
FrameError  output  1  stop bit sampled 0, for the last frame.
Busy  output  1  high in every state except IDLE.

Behaviour:
- Frame on the line: idle 1, start 0, D[0]..D[8], parity P, stop 1.
- Expected P = Parity ^ XOR(D); this matches the transmitter rule.
- Rx passes through a 2-FF synchroniser before use. Both FFs reset to 1.
- Reset (synchronous, overrides everything, including mid-frame):
  - state IDLE; tick counter and bit counter 0.
  - Data=0, DataReady=0, ParityError=0, FrameError=0, Busy=0.
  - No partial word is ever published.
- Tick counter advances only on SampleTick. Nothing happens on Clock cycles without SampleTick.
- States:
  - IDLE: on SampleTick with RxSync==0, go to START and set tick count 0.
  - START: on each tick, count++. At count==Oversample/2-1 (mid start bit):
    - if RxSync==0: latch Parity, clear count, go to DATA.
    - else (glitch/false start): go to IDLE, no outputs change.
  - DATA: at count==Oversample-1:
    - shift RxSync into the word MSB with a right shift, so D[0] ends in bit 0; count=0; bitcnt++.
    - after DataLength bits, go to PARITY.
  - PARITY: at count==Oversample-1, capture the P bit and go to STOP.
  - STOP: at count==Oversample-1, sample the stop bit. On the next Clock edge:
    - Data=word.
    - ParityError = P ^ LatchedParity ^ XOR(word).
    - FrameError = ~stop.
    - DataReady=1 for exactly one Clock.
    - go to IDLE.
- Word and flags are always published together, even when an error is flagged. The flags hold until the next publish.
- A stop bit of 0 (break) returns to IDLE. If the line stays low, the next tick starts a new frame.
- Latency: DataReady follows the stop mid-sample tick by 1 Clock, which is about 11.5 bit periods after the start falling edge.
- Changes to Parity mid-frame are ignored, because of the latch at START.
- If SampleTick is stuck high, the unit still functions at 1 bit per Oversample Clocks.

Decomposition:
- Shared package rx_tx_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP;
  - FRAME_BITS=12;
  - START_BIT=0, STOP_BIT=1;
  - EVEN_PARITY=0, ODD_PARITY=1.
- One sub-module, rx_sync_2ff: the 2-stage synchroniser with reset value 1. The Tx side and other pin inputs reuse it.
- FSM, counters and the shift register stay in the top module.

Test Plan:
All scenarios use Oversample=16 and a SampleTick every 4 Clocks.
1. Parity=0; frame D=9'h1A5, P=1, stop=1 -> one DataReady pulse; Data=9'h1A5; ParityError=0; FrameError=0; Busy low afterward.
2. Parity=1; frame D=9'h0FF, P=1 -> Data=9'h0FF, no errors. Same frame with P=0 -> ParityError=1, Data=9'h0FF.
3. Parity=0; D=9'h1A5 with stop=0 -> DataReady pulse, FrameError=1, ParityError=0. Line then held low for 2 frames -> repeated FrameError frames with Data=9'h000.
4. Rx low for 5 ticks, then high -> state returns to IDLE; no DataReady; Data and flags unchanged from the prior frame.
5. Reset asserted for 1 Clock during data bit 4 -> all outputs 0 on the next edge, no DataReady. The next full frame D=9'h055, Parity=0, P=0 -> Data=9'h055, no errors.
6. Frames 9'h001, 9'h100, 9'h1FF sent back-to-back with no idle gap, driven by the Tx data unit model -> three DataReady pulses in order with the matching Data values, all flags 0.
